// File: rtl/memwb_pkg.sv
// Shared definitions for the MEM->WB elastic stage: load funct3 codes and
// the payload record carried through the two-entry skid buffer.
package memwb_pkg;

   // RISC-V load size/sign codes.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // Widest legal configuration. Each field is sized for it; an instance
   // with narrower widths zero-extends on entry and uses the low bits.
   localparam int MAX_ADDR_WIDTH  = 64;
   localparam int MAX_DATA_WIDTH  = 64;
   localparam int MAX_RADDR_WIDTH = 8;

   typedef struct packed {
      logic [MAX_ADDR_WIDTH-1:0]  pc;
      logic [MAX_DATA_WIDTH-1:0]  alu;
      logic [MAX_DATA_WIDTH-1:0]  mem;
      logic [MAX_RADDR_WIDTH-1:0] rd;
      logic [2:0]                 funct3;
      logic                       memtoreg;
      logic                       regwrite;
   } memwb_payload_t;

   // Number of byte-offset bits within one data word.
   function automatic int off_width(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it according to the load funct3 code.
module load_extend
   import memwb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OFF_WIDTH  = 2
) (
   input  logic [DATA_WIDTH-1:0] word,
   input  logic [OFF_WIDTH-1:0]  off,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] ext
);

   logic [DATA_WIDTH-1:0] lane;

   // Misaligned offsets are not trapped here; the shift is applied as-is.
   assign lane = word >> {off, 3'b000};

   // Select extension by load code; codes without a meaning at this width
   // pass the unshifted word through.
   always_comb begin
      ext = word;
      case (funct3)
         F3_LB:  ext = DATA_WIDTH'($signed(lane[7:0]));
         F3_LBU: ext = DATA_WIDTH'(lane[7:0]);
         F3_LH:  ext = DATA_WIDTH'($signed(lane[15:0]));
         F3_LHU: ext = DATA_WIDTH'(lane[15:0]);
         F3_LW:  ext = DATA_WIDTH'($signed(lane[31:0]));
         F3_LWU: begin
            if (DATA_WIDTH == 64) ext = DATA_WIDTH'(lane[31:0]);
         end
         F3_LD: begin
            if (DATA_WIDTH == 64) ext = lane;
         end
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/memwb_skid_stage.sv
// Elastic MEM->WB stage: two-entry skid buffer (head drives the outputs,
// skid catches the beat that arrives while head is blocked), load
// extension and MemtoReg select on the head entry, and a saturating
// back-pressure counter.
//
// Handshake: a beat transfers on any edge where valid && ready are both
// high; the sender holds valid and payload stable until it transfers.
// in_ready is taken straight from the skid-valid register, so nothing
// arriving on in_valid or out_ready can reach it combinationally.
module memwb_skid_stage
   import memwb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_ADDR     = ADDR_WIDTH'(32'h8000_0000),
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    RADDR_WIDTH = 5,
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDR_WIDTH-1:0]  in_pc,
   input  logic [DATA_WIDTH-1:0]  in_alu,
   input  logic [DATA_WIDTH-1:0]  in_mem,
   input  logic [RADDR_WIDTH-1:0] in_rd,
   input  logic [2:0]             in_funct3,
   input  logic                   in_memtoreg,
   input  logic                   in_regwrite,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_WIDTH-1:0]  out_pc,
   output logic [DATA_WIDTH-1:0]  out_wdata,
   output logic [RADDR_WIDTH-1:0] out_rd,
   output logic                   out_we,
   output logic [1:0]             occupancy,
   output logic [CNT_WIDTH-1:0]   stall_cycles
);

   localparam int OFF_WIDTH = off_width(DATA_WIDTH);

   // Head payload after reset or flush: PC_ADDR with everything else zero.
   localparam memwb_payload_t RST_BEAT = '{pc: MAX_ADDR_WIDTH'(PC_ADDR), default: '0};

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
      $error("memwb_skid_stage: DATA_WIDTH must be 32 or 64");
   end
   if (ADDR_WIDTH > MAX_ADDR_WIDTH || RADDR_WIDTH > MAX_RADDR_WIDTH) begin : g_bad_width
      $error("memwb_skid_stage: ADDR_WIDTH or RADDR_WIDTH exceeds payload field size");
   end

   memwb_payload_t         in_beat;
   memwb_payload_t         head_q, head_d;
   memwb_payload_t         skid_q, skid_d;
   logic                   head_valid_q, head_valid_d;
   logic                   skid_valid_q, skid_valid_d;
   logic [CNT_WIDTH-1:0]   stall_q, stall_d;
   logic                   accept;
   logic                   retire;
   logic [DATA_WIDTH-1:0]  ext_data;

   assign in_ready = !skid_valid_q;
   assign accept   = in_valid && in_ready;
   assign retire   = head_valid_q && out_ready;

   // Pack the incoming beat into the payload record.
   always_comb begin
      in_beat          = '0;
      in_beat.pc       = MAX_ADDR_WIDTH'(in_pc);
      in_beat.alu      = MAX_DATA_WIDTH'(in_alu);
      in_beat.mem      = MAX_DATA_WIDTH'(in_mem);
      in_beat.rd       = MAX_RADDR_WIDTH'(in_rd);
      in_beat.funct3   = in_funct3;
      in_beat.memtoreg = in_memtoreg;
      in_beat.regwrite = in_regwrite;
   end

   // Buffer next state: flush wins, then skid->head refill, then accept.
   // When skid is full in_ready is low, so refill and accept never collide.
   always_comb begin
      head_d       = head_q;
      skid_d       = skid_q;
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         head_d       = RST_BEAT;
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (retire && skid_valid_q) begin
         head_d       = skid_q;
         skid_valid_d = 1'b0;
      end else if (accept && (!head_valid_q || retire)) begin
         head_d       = in_beat;
         head_valid_d = 1'b1;
      end else if (accept) begin
         skid_d       = in_beat;
         skid_valid_d = 1'b1;
      end else if (retire) begin
         head_valid_d = 1'b0;
      end
   end

   // Back-pressure counter: count blocked head cycles, hold at all-ones.
   always_comb begin
      stall_d = stall_q;
      if (head_valid_q && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // State registers; reset empties both entries immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q       <= RST_BEAT;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         stall_q      <= stall_d;
      end
   end

   load_extend #(
      .DATA_WIDTH (DATA_WIDTH),
      .OFF_WIDTH  (OFF_WIDTH)
   ) u_load_extend (
      .word   (head_q.mem[DATA_WIDTH-1:0]),
      .off    (head_q.alu[OFF_WIDTH-1:0]),
      .funct3 (head_q.funct3),
      .ext    (ext_data)
   );

   assign out_valid    = head_valid_q;
   assign out_pc       = head_q.pc[ADDR_WIDTH-1:0];
   assign out_rd       = head_q.rd[RADDR_WIDTH-1:0];
   assign out_wdata    = head_q.memtoreg ? ext_data : head_q.alu[DATA_WIDTH-1:0];
   assign out_we       = head_valid_q && head_q.regwrite && (head_q.rd[RADDR_WIDTH-1:0] != '0);
   assign occupancy    = 2'(head_valid_q) + 2'(skid_valid_q);
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// queue-based model of the stage.
module tb_memwb_skid_stage;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 4;
   localparam logic [AW-1:0] PC_RST = 32'h8000_0000;
   localparam int EW = AW + DW + RW + 1;
   localparam logic [CW-1:0] STALL_MAX = '1;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_pc;
   logic [DW-1:0] in_alu;
   logic [DW-1:0] in_mem;
   logic [RW-1:0] in_rd;
   logic [2:0]    in_funct3;
   logic          in_memtoreg;
   logic          in_regwrite;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_pc;
   logic [DW-1:0] out_wdata;
   logic [RW-1:0] out_rd;
   logic          out_we;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cycles;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   memwb_skid_stage #(
      .ADDR_WIDTH  (AW),
      .PC_ADDR     (PC_RST),
      .DATA_WIDTH  (DW),
      .RADDR_WIDTH (RW),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_alu       (in_alu),
      .in_mem       (in_mem),
      .in_rd        (in_rd),
      .in_funct3    (in_funct3),
      .in_memtoreg  (in_memtoreg),
      .in_regwrite  (in_regwrite),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_wdata    (out_wdata),
      .out_rd       (out_rd),
      .out_we       (out_we),
      .occupancy    (occupancy),
      .stall_cycles (stall_cycles)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit armed = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Expected write-back for a load, from the RISC-V load rules.
   function automatic logic [DW-1:0] ext_model(input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                                                input logic [2:0] f3);
      logic [DW-1:0] lane;
      logic [DW-1:0] r;
      int unsigned   off;
      off  = alu % 4;
      lane = mem >> (off * 8);
      case (f3)
         3'd0: begin r = lane & 32'hFF;   if (r >= 32'd128)   r = r + 32'hFFFF_FF00; end
         3'd4: r = lane & 32'hFF;
         3'd1: begin r = lane & 32'hFFFF; if (r >= 32'd32768) r = r + 32'hFFFF_0000; end
         3'd5: r = lane & 32'hFFFF;
         3'd2: r = lane;
         default: r = mem;
      endcase
      return r;
   endfunction

   // Expected head beats in order: {pc, wdata, rd, we}.
   logic [EW-1:0] exp_q[$];
   logic [CW-1:0] m_stall;
   bit            m_fresh;
   bit            m_ret;
   bit            m_acc;
   logic [DW-1:0] m_wdata;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         m_stall = '0;
         m_fresh = 1'b1;
      end else begin
         m_ret = (exp_q.size() > 0) && out_ready;
         m_acc = in_valid && (exp_q.size() < 2);
         if ((exp_q.size() > 0) && !out_ready && (m_stall != STALL_MAX)) m_stall = m_stall + 1'b1;
         if (flush) begin
            exp_q.delete();
            m_fresh = 1'b1;
         end else begin
            if (m_ret) void'(exp_q.pop_front());
            if (m_acc) begin
               m_wdata = in_memtoreg ? ext_model(in_mem, in_alu, in_funct3) : in_alu;
               exp_q.push_back({in_pc, m_wdata, in_rd, in_regwrite && (in_rd != 0)});
               m_fresh = 1'b0;
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   logic [AW-1:0] e_pc;
   logic [DW-1:0] e_wdata;
   logic [RW-1:0] e_rd;
   logic          e_we;

   always @(negedge clk) begin
      if (armed) begin
         if (reset) begin
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_pc", out_pc, PC_RST);
            check("rst_out_wdata", out_wdata, 0);
            check("rst_out_rd", out_rd, 0);
            check("rst_out_we", out_we, 1'b0);
            check("rst_occupancy", occupancy, 0);
            check("rst_stall", stall_cycles, 0);
         end else begin
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() < 2);
            check("occupancy", occupancy, exp_q.size());
            check("stall_cycles", stall_cycles, m_stall);
            if (exp_q.size() != 0) begin
               {e_pc, e_wdata, e_rd, e_we} = exp_q[0];
               check("out_pc", out_pc, e_pc);
               check("out_wdata", out_wdata, e_wdata);
               check("out_rd", out_rd, e_rd);
               check("out_we", out_we, e_we);
            end else begin
               check("idle_out_we", out_we, 1'b0);
               if (m_fresh) begin
                  check("idle_out_pc", out_pc, PC_RST);
                  check("idle_out_wdata", out_wdata, 0);
                  check("idle_out_rd", out_rd, 0);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_beat(input logic [AW-1:0] pc, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                           input logic [RW-1:0] rd, input logic [2:0] f3, input logic m2r, input logic rw);
      in_pc       = pc;
      in_alu      = alu;
      in_mem      = mem;
      in_rd       = rd;
      in_funct3   = f3;
      in_memtoreg = m2r;
      in_regwrite = rw;
   endtask

   // Present one beat and hold it until it is taken; returns at edge+1.
   task automatic send(input logic [AW-1:0] pc, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                       input logic [RW-1:0] rd, input logic [2:0] f3, input logic m2r, input logic rw);
      bit done;
      int budget;
      done   = 1'b0;
      budget = 0;
      set_beat(pc, alu, mem, rd, f3, m2r, rw);
      in_valid = 1'b1;
      while (!done) begin
         done = in_ready;
         @(posedge clk);
         #1;
         if (!done) begin
            budget++;
            if (budget > 50) begin
               n_checks++;
               n_errors++;
               $display("FAIL send_timeout: in_ready stayed 0 for pc %0h", pc);
               done = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      set_beat('0, '0, '0, '0, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      armed = 1'b1;
      @(negedge clk);
      check("lit_rst_out_pc", out_pc, 32'h8000_0000);
      check("lit_rst_in_ready", in_ready, 1'b1);
      step();
      reset = 1'b0;

      // LB from byte 3 of 32'h80FF_1234 -> 0x80 sign-extended.
      out_ready = 1'b1;
      send(32'h0000_0100, 32'h0000_2003, 32'h80FF_1234, 5'd3, 3'b000, 1'b1, 1'b1);
      @(negedge clk);
      check("lit_lb_valid", out_valid, 1'b1);
      check("lit_lb_wdata", out_wdata, 32'hFFFF_FF80);
      check("lit_lb_we", out_we, 1'b1);
      step();

      // Streaming 8 beats at full rate.
      for (int i = 0; i < 8; i++) begin
         set_beat(32'h200 + 4 * i, $urandom, $urandom, 5'($urandom_range(1, 31)), 3'b010, 1'b0, 1'b1);
         in_valid = 1'b1;
         @(negedge clk);
         check("lit_stream_in_ready", in_ready, 1'b1);
         if (i > 0) check("lit_stream_pc", out_pc, 32'h200 + 4 * (i - 1));
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_stream_last_pc", out_pc, 32'h21C);
      check("lit_stream_stall", stall_cycles, 0);
      step();

      // Back-pressure: three beats into a blocked stage.
      out_ready = 1'b0;
      set_beat(32'h300, 32'h11, 32'h0, 5'd1, 3'b010, 1'b0, 1'b1);
      in_valid = 1'b1;
      step();
      set_beat(32'h304, 32'h22, 32'h0, 5'd2, 3'b010, 1'b0, 1'b1);
      @(negedge clk);
      check("lit_bp_occ1", occupancy, 1);
      step();
      set_beat(32'h308, 32'h33, 32'h0, 5'd3, 3'b010, 1'b0, 1'b1);
      @(negedge clk);
      check("lit_bp_occ2", occupancy, 2);
      check("lit_bp_in_ready", in_ready, 1'b0);
      step();
      @(negedge clk);
      check("lit_bp_held_occ", occupancy, 2);
      check("lit_bp_head_a", out_pc, 32'h300);
      out_ready = 1'b1;
      step();
      @(negedge clk);
      check("lit_bp_head_b", out_pc, 32'h304);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_bp_head_c", out_pc, 32'h308);
      step();
      @(negedge clk);
      check("lit_bp_drained", out_valid, 1'b0);
      step();

      // Flush with both entries full and a beat presented.
      out_ready = 1'b0;
      set_beat(32'h400, 32'h44, 32'h0, 5'd4, 3'b010, 1'b0, 1'b1);
      in_valid = 1'b1;
      step();
      set_beat(32'h404, 32'h55, 32'h0, 5'd5, 3'b010, 1'b0, 1'b1);
      step();
      set_beat(32'h408, 32'h66, 32'h0, 5'd6, 3'b010, 1'b0, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      check("lit_fl_occ_before", occupancy, 2);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_fl_valid", out_valid, 1'b0);
      check("lit_fl_occ", occupancy, 0);
      check("lit_fl_pc", out_pc, 32'h8000_0000);
      step();
      step();

      // Flush with one held beat, a beat presented and a retire.
      out_ready = 1'b1;
      send(32'h480, 32'h77, 32'h0, 5'd7, 3'b010, 1'b0, 1'b1);
      set_beat(32'h484, 32'h88, 32'h0, 5'd8, 3'b010, 1'b0, 1'b1);
      in_valid = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_flret_occ", occupancy, 0);
      step();

      // rd = 0 suppresses the write; memtoreg = 0 passes the ALU result.
      send(32'h500, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 3'b010, 1'b0, 1'b1);
      @(negedge clk);
      check("lit_rd0_we", out_we, 1'b0);
      check("lit_alu_wdata", out_wdata, 32'hDEAD_BEEF);
      step();

      // Saturating stall counter, then reset mid-stall.
      out_ready = 1'b0;
      send(32'h600, 32'h99, 32'h0, 5'd9, 3'b010, 1'b0, 1'b1);
      repeat (20) step();
      @(negedge clk);
      check("lit_stall_sat", stall_cycles, 4'd15);
      step();
      reset = 1'b1;
      #1;
      check("lit_async_valid", out_valid, 1'b0);
      check("lit_async_occ", occupancy, 0);
      check("lit_async_stall", stall_cycles, 0);
      check("lit_async_pc", out_pc, 32'h8000_0000);
      step();
      reset = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         set_beat($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 31) == 0);
         reset     = (i == 700);
         step();
      end
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
